// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, shared sample divider, per-key
// saturating stability counter, registered press/release pulses and a priority encoder.
module key_debounce #(
  parameter int NUM_KEYS       = 7,
  parameter int ACTIVE_LOW     = 1,
  parameter int SAMPLE_DIV     = 50000,
  parameter int STABLE_SAMPLES = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                key_valid,
  output logic [2:0]          key_code
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [NUM_KEYS-1:0] IDLE_RAW = {NUM_KEYS{POL}};
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_SAMPLES - 1);

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tick;
  logic [2:0]          code_d;

  // Synchronisers idle at the "not pressed" pin level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
      div_q   <= '0;
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
      div_q   <= div_d;
    end
  end

  assign tick = (div_q == DIV_MAX);

  always_comb begin
    div_d = div_q + 1'b1;
    if (tick) begin
      div_d = '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             release_q, release_d;
      logic             s;

      assign s = sync2_q[gi] ^ POL;

      // Any sample agreeing with the current level restarts the count, so bounce is rejected.
      always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
          if (s == level_q) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_MAX) begin
            cnt_d     = '0;
            level_d   = ~level_q;
            press_d   = ~level_q;
            release_d = level_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q     <= '0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          cnt_q     <= cnt_d;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
        end
      end

      assign key_level[gi]   = level_q;
      assign key_press[gi]   = press_q;
      assign key_release[gi] = release_q;
    end
  endgenerate

  // Descending scan so the lowest pressed index wins.
  always_comb begin
    code_d = 3'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_press[i]) begin
        code_d = 3'(i);
      end
    end
  end

  assign key_valid = |key_press;
  assign key_code  = code_d;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a short divider and stability count.
module tb_key_debounce;

  logic       clk;
  logic       rst;
  logic [6:0] keys_raw;
  logic [6:0] key_level;
  logic [6:0] key_press;
  logic [6:0] key_release;
  logic       key_valid;
  logic [2:0] key_code;

  int checks = 0;
  int errors = 0;
  int press_cnt [7] = '{default: 0};
  int rel_cnt   [7] = '{default: 0};

  key_debounce #(
    .NUM_KEYS(7), .ACTIVE_LOW(1), .SAMPLE_DIV(4), .STABLE_SAMPLES(3)
  ) dut (
    .clk(clk), .rst(rst), .keys_raw(keys_raw), .key_level(key_level),
    .key_press(key_press), .key_release(key_release),
    .key_valid(key_valid), .key_code(key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tally, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 7; i++) begin
        press_cnt[i] = press_cnt[i] + int'(key_press[i]);
        rel_cnt[i]   = rel_cnt[i] + int'(key_release[i]);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_level(input int k, input logic v, output int n);
    n = 99;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (key_level[k] === v) begin
        n = e;
        break;
      end
    end
  endtask

  function automatic logic [31:0] all_out();
    return {7'd0, key_level, key_press, key_release, key_valid, key_code};
  endfunction

  initial begin
    int n;
    int pb;
    int rb;

    // Reset and idle
    rst = 1'b1;
    keys_raw = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_out(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      check("idle_outputs", all_out(), 32'd0);
    end
    $display("idle: 40 clks with all keys released");

    // Clean press/release of key 2
    pb = press_cnt[2];
    rb = rel_cnt[2];
    @(negedge clk);
    keys_raw[2] = 1'b0;
    wait_level(2, 1'b1, n);
    check("k2_press_latency_ok", 32'(n >= 11 && n <= 14), 32'd1);
    check("k2_press_vec", 32'(key_press), 32'h04);
    check("k2_valid", 32'(key_valid), 32'd1);
    check("k2_code", 32'(key_code), 32'd2);
    check("k2_no_release", 32'(key_release), 32'd0);
    @(posedge clk);
    #1;
    check("k2_press_one_clk", 32'(key_press), 32'd0);
    check("k2_level_held", 32'(key_level), 32'h04);
    $display("key2 press: latency %0d clks", n);
    @(negedge clk);
    keys_raw[2] = 1'b1;
    wait_level(2, 1'b0, n);
    check("k2_release_latency_ok", 32'(n >= 11 && n <= 14), 32'd1);
    check("k2_release_vec", 32'(key_release), 32'h04);
    check("k2_release_no_press", 32'(key_press), 32'd0);
    check("k2_release_valid", 32'(key_valid), 32'd0);
    @(posedge clk);
    #1;
    check("k2_release_one_clk", 32'(key_release), 32'd0);
    repeat (20) @(negedge clk);
    check("k2_single_press", 32'(press_cnt[2] - pb), 32'd1);
    check("k2_single_release", 32'(rel_cnt[2] - rb), 32'd1);
    $display("key2 release: latency %0d clks", n);

    // Bounce on key 0
    pb = press_cnt[0];
    rb = rel_cnt[0];
    keys_raw[0] = 1'b0;
    repeat (5) @(negedge clk);
    keys_raw[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("bounce_level_low", 32'(key_level[0]), 32'd0);
    check("bounce_no_press", 32'(press_cnt[0] - pb), 32'd0);
    keys_raw[0] = 1'b0;
    repeat (30) @(negedge clk);
    check("bounce_one_press", 32'(press_cnt[0] - pb), 32'd1);
    check("bounce_no_release", 32'(rel_cnt[0] - rb), 32'd0);
    check("bounce_level_high", 32'(key_level[0]), 32'd1);
    keys_raw[0] = 1'b1;
    repeat (30) @(negedge clk);
    check("bounce_final_release", 32'(rel_cnt[0] - rb), 32'd1);
    $display("bounce key0: presses %0d releases %0d", press_cnt[0] - pb, rel_cnt[0] - rb);

    // Simultaneous keys 5 and 3
    keys_raw[5] = 1'b0;
    keys_raw[3] = 1'b0;
    wait_level(3, 1'b1, n);
    check("simul_latency_ok", 32'(n >= 11 && n <= 14), 32'd1);
    check("simul_press_vec", 32'(key_press), 32'h28);
    check("simul_code", 32'(key_code), 32'd3);
    check("simul_valid", 32'(key_valid), 32'd1);
    $display("simultaneous 5+3: press %0h code %0d", key_press, key_code);
    @(negedge clk);
    keys_raw = 7'h7F;
    repeat (30) @(negedge clk);
    check("simul_released", 32'(key_level), 32'd0);

    // Reset during debounce of key 6
    pb = press_cnt[6];
    keys_raw[6] = 1'b0;
    repeat (8) @(negedge clk);
    check("k6_no_early_press", 32'(press_cnt[6] - pb), 32'd0);
    rst = 1'b1;
    #1;
    check("k6_rst_async_clear", all_out(), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("k6_during_reset", all_out(), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_level(6, 1'b1, n);
    check("k6_latency_ok", 32'(n >= 11 && n <= 14), 32'd1);
    check("k6_press_vec", 32'(key_press), 32'h40);
    check("k6_code", 32'(key_code), 32'd6);
    repeat (20) @(negedge clk);
    check("k6_single_press", 32'(press_cnt[6] - pb), 32'd1);
    $display("reset mid-debounce key6: latency %0d clks after release", n);
    keys_raw = 7'h7F;
    repeat (30) @(negedge clk);

    // Long hold of key 1
    pb = press_cnt[1];
    rb = rel_cnt[1];
    keys_raw[1] = 1'b0;
    repeat (200) @(negedge clk);
    check("hold_one_press", 32'(press_cnt[1] - pb), 32'd1);
    check("hold_no_release", 32'(rel_cnt[1] - rb), 32'd0);
    check("hold_level", 32'(key_level), 32'h02);
    check("hold_no_pulse_now", 32'(key_press), 32'd0);
    $display("held key1 200 clks: presses %0d", press_cnt[1] - pb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input conditioning stage sitting directly upstream of the menu/sub-module logic in the top level. It replaces the raw `keys` bus those blocks currently read.
- Synchronises the raw push-button bus to `clk` and debounces each key independently.
- Produces clean levels, single-cycle press/release pulses and an encoded key code, so menu and sub-modules react once per physical press.

Parameters:
- NUM_KEYS, 7, number of key inputs; legal range 1..8.
- ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = raw key reads 1 when pressed.
- SAMPLE_DIV, 50000, clk cycles between debounce samples (1 ms at 50 MHz); legal minimum 2.
- STABLE_SAMPLES, 20, consecutive differing samples required to accept a new level; legal range 2..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- keys_raw  in  NUM_KEYS  raw button pins, asynchronous to clk.
- key_level  out  NUM_KEYS  debounced level, 1 = pressed (polarity normalised).
- key_press  out  NUM_KEYS  one-clk pulse on debounced 0->1.
- key_release  out  NUM_KEYS  one-clk pulse on debounced 1->0.
- key_valid  out  1  OR of key_press.
- key_code  out  3  index of lowest-numbered key with key_press set; 0 when key_valid=0.

Behaviour:
- Reset (async assert, sync deassert by design of upstream reset):
  - Sync flops load the "not pressed" raw level (all 1s if ACTIVE_LOW).
  - Divider, all per-key counters, key_level, key_press and key_release clear to 0.
  - key_valid=0, key_code=0.
- Synchroniser:
  - 2-flop per key.
  - Normalised sample s[i] = sync2[i] XOR ACTIVE_LOW.
- Sample tick:
  - Shared divider counts 0..SAMPLE_DIV-1 and wraps.
  - tick=1 for exactly one clk when the divider equals SAMPLE_DIV-1.
  - First tick occurs at cycle SAMPLE_DIV-1 after reset release.
- Per-key counter (width ceil(log2(STABLE_SAMPLES))), evaluated only on tick:
  - s[i]==key_level[i]: cnt cleared to 0.
  - s[i]!=key_level[i] and cnt<STABLE_SAMPLES-1: cnt+1.
  - s[i]!=key_level[i] and cnt==STABLE_SAMPLES-1: key_level[i] toggles and cnt clears, on the same edge.
  - Off-tick cycles: cnt and key_level hold.
- Pulses:
  - key_press[i] and key_release[i] are registered and asserted on the same edge key_level[i] toggles.
  - They are high for exactly one clk; they are never both high for the same key.
- Encoder:
  - key_valid and key_code are combinational from the key_press register, with no extra latency.
  - Simultaneous presses: all key_press bits set; key_code reports the lowest index. Higher-index presses are visible only via key_press.
- Latency, raw edge to key_level change for a clean step: at least 2+(STABLE_SAMPLES-1)*SAMPLE_DIV+1 clks; at most 2+STABLE_SAMPLES*SAMPLE_DIV clks.
- Glitch rejection:
  - Any excursion seen on fewer than STABLE_SAMPLES consecutive ticks is discarded.
  - A single matching sample clears cnt, so bounce restarts the count.
- Key held through reset: key_level starts at 0 after reset, then debounces to 1 and emits one key_press. This is intentional.
- Reset mid-debounce: partial counts are lost. No pulse is emitted during or immediately at reset release.
- Unused code bits: with NUM_KEYS<8, key_code never exceeds NUM_KEYS-1.

Test Plan (bench params NUM_KEYS=7, ACTIVE_LOW=1, SAMPLE_DIV=4, STABLE_SAMPLES=3):
- Reset, keys_raw=7'h7F held 40 clks -> all outputs 0 throughout; first tick seen at cycle 3.
- Reset state: keys_raw[2]->0 cleanly, held -> key_level[2] rises 11..14 clks after the raw edge; key_press=7'h04 for one clk; key_valid=1 and key_code=2 in that clk. keys_raw[2]->1 -> key_release[2] one-clk pulse after the same latency; no second press.
- Bounce: keys_raw[0] low 5 clks, high 3 clks, low held -> no pulse from the first burst; exactly one key_press[0] after the final stable low; no key_release.
- Simultaneous: keys_raw[5] and keys_raw[3] fall on the same clk -> key_press=7'h28 in one clk; key_code=3; key_valid=1.
- Reset mid-operation: keys_raw[6] low, assert rst after 8 clks for 2 clks, keep key low -> no pulse during reset; single key_press[6] 11..14 clks after rst release.
- Held key: keys_raw[1] low 200 clks -> exactly one key_press[1]; key_level[1] stays 1; no repeat pulses.
